// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, bit-counter width, FSM encoding and the
// default byte returned when no TX byte is pending.
package spi_pkg;

   localparam int unsigned SPI_FRAME_BITS = 8;
   localparam int unsigned SPI_CNT_W      = $clog2(SPI_FRAME_BITS);

   localparam logic [SPI_FRAME_BITS-1:0] SPI_TX_IDLE_BYTE = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser plus history flop; flags single-cycle rise/fall
// pulses from the compare of the last stage with the history flop.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_c = level & ~hist_q;
   assign fall_c = ~level & hist_q;

endmodule : spi_sync_edge

// File: rtl/simple_spi_slave.sv
// SPI mode-0 responder: 8-bit MSB-first frames, pins oversampled in the clk domain.
// Sticky RX overrun flag is built only when SIMPLE_SPI_SLAVE_OVERRUN_EN is defined.
module simple_spi_slave
   import spi_pkg::*;
#(
   parameter logic [SPI_FRAME_BITS-1:0] TX_IDLE_BYTE = SPI_TX_IDLE_BYTE,
   parameter int unsigned               SYNC_STAGES  = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      spi_clk,
   input  logic                      spi_cs_n,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   output logic                      spi_miso_oe,
   input  logic [SPI_FRAME_BITS-1:0] tx_data,
   input  logic                      tx_load,
   output logic                      tx_empty,
   output logic [SPI_FRAME_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ack,
   output logic                      overrun,
   output logic                      selected
);

   localparam int unsigned FB = SPI_FRAME_BITS;

   // Reset asserts asynchronously, releases on a clk edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   logic sclk_unused, sclk_rise, sclk_fall, cs_fall, cs_rise;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .reset_n(rst_n),
      .din    (spi_clk),
      .level  (sclk_unused),
      .rise_c (sclk_rise),
      .fall_c (sclk_fall)
   );

   // Chip select is synchronised inverted so that the last stage is 'selected'.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
      .clk    (clk),
      .reset_n(rst_n),
      .din    (~spi_cs_n),
      .level  (selected),
      .rise_c (cs_fall),
      .fall_c (cs_rise)
   );

   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_q <= '0;
      else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   spi_state_e             state_q, state_n;
   logic [SPI_CNT_W-1:0]   bit_cnt_q, bit_cnt_n;
   logic [FB-1:0]          tx_shift_q, tx_shift_n;
   logic [FB-1:0]          rx_shift_q, rx_shift_n;
   logic [FB-1:0]          hold_q, hold_n;
   logic [FB-1:0]          rx_data_n, rx_word, reload_byte;
   logic                   tx_empty_n, rx_valid_n, miso_n, oe_n;
   logic                   reload, byte_done;

   assign rx_word     = {rx_shift_q[FB-2:0], mosi_s};
   assign reload_byte = tx_empty ? TX_IDLE_BYTE : hold_q;

   always_comb begin
      state_n    = state_q;
      bit_cnt_n  = bit_cnt_q;
      tx_shift_n = tx_shift_q;
      rx_shift_n = rx_shift_q;
      hold_n     = hold_q;
      tx_empty_n = tx_empty;
      miso_n     = spi_miso;
      oe_n       = spi_miso_oe;
      reload     = 1'b0;
      byte_done  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            oe_n      = 1'b0;
            bit_cnt_n = '0;
            if (cs_fall) begin
               state_n    = ST_ACTIVE;
               reload     = 1'b1;
               tx_shift_n = reload_byte;
               miso_n     = reload_byte[FB-1];
               oe_n       = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // A deselect in the same cycle as an SCLK edge swallows the edge.
            if (cs_rise) begin
               state_n   = ST_IDLE;
               oe_n      = 1'b0;
               bit_cnt_n = '0;
            end else if (sclk_rise) begin
               rx_shift_n = rx_word;
               if (bit_cnt_q == SPI_CNT_W'(FB - 1)) begin
                  byte_done  = 1'b1;
                  reload     = 1'b1;
                  bit_cnt_n  = '0;
                  tx_shift_n = reload_byte;
               end else begin
                  bit_cnt_n  = bit_cnt_q + SPI_CNT_W'(1);
                  tx_shift_n = {tx_shift_q[FB-2:0], 1'b0};
               end
            end else if (sclk_fall) begin
               miso_n = tx_shift_q[FB-1];
            end
         end
      endcase

      // Reload consumes the old holding value; a same-cycle load becomes pending.
      if (reload)  tx_empty_n = 1'b1;
      if (tx_load) begin
         hold_n     = tx_data;
         tx_empty_n = 1'b0;
      end

      rx_valid_n = byte_done | (rx_valid & ~rx_ack);
      rx_data_n  = byte_done ? rx_word : rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         hold_q      <= '0;
         tx_empty    <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else begin
         state_q     <= state_n;
         bit_cnt_q   <= bit_cnt_n;
         tx_shift_q  <= tx_shift_n;
         rx_shift_q  <= rx_shift_n;
         hold_q      <= hold_n;
         tx_empty    <= tx_empty_n;
         rx_data     <= rx_data_n;
         rx_valid    <= rx_valid_n;
         spi_miso    <= miso_n;
         spi_miso_oe <= oe_n;
      end
   end

`ifdef SIMPLE_SPI_SLAVE_OVERRUN_EN
   logic overrun_n;

   always_comb begin
      overrun_n = overrun;
      if (byte_done && rx_valid && !rx_ack) overrun_n = 1'b1;
      else if (rx_ack)                      overrun_n = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun <= 1'b0;
      else        overrun <= overrun_n;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule : simple_spi_slave

// File: doc/simple_spi_slave.md
Name: simple_spi_slave

Overview:
- SPI responder (Mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames); counterpart to the SPI master.
- Oversamples the external SPI pins in the system clock domain and receives and transmits one byte per 8 SCLK cycles.
- Supports back-to-back bytes within one chip-select assertion.
- Used where the FPGC is attached as a peripheral to an external controller (debug/boot link).

Parameters:
- TX_IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is pending at a byte boundary.
- SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_cs_n/spi_mosi (legal 2..3).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  SCLK from master, asynchronous.
- spi_cs_n  in  1  chip select from master, active low, asynchronous.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data (registered).
- spi_miso_oe  out  1  tri-state enable for MISO pad; high while selected.
- tx_data  in  8  next byte to transmit.
- tx_load  in  1  one-cycle strobe; writes tx_data to the TX holding register.
- tx_empty  out  1  high when no TX byte is pending.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  high from byte completion until rx_ack.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- overrun  out  1  sticky overrun flag (see Optional Feature).
- selected  out  1  synchronised, inverted chip select.

Behaviour:
- Reset (async assert, sync deassert internally): spi_miso=0, spi_miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, overrun=0, selected=0, bit_cnt=0, state=IDLE, synchronisers=idle (clk=0, cs_n=1).
- Synchronisers: SYNC_STAGES flops, plus one history flop per signal. An edge is detected on the compare of the last stage and the history flop. Pin-to-action latency is SYNC_STAGES+1 clk.
- Timing requirement: each SCLK half-period must be at least 4 clk, i.e. f_sclk <= f_clk/8. Faster SCLK is out of spec and has no defined behaviour.
- State IDLE, cs_n synchronised high:
  - spi_miso_oe=0, bit_cnt=0.
  - On the falling edge of synchronised cs_n: go to ACTIVE.
  - tx_shift <= holding if pending, else TX_IDLE_BYTE; clear pending; spi_miso <= that byte's bit 7; spi_miso_oe=1.
- State ACTIVE:
  - SCLK rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++.
  - SCLK rising edge with bit_cnt 0..6: tx_shift <= tx_shift<<1.
  - SCLK rising edge with bit_cnt==7 (byte done):
    - rx_data <= {rx_shift[6:0], mosi}; rx_valid <= 1; bit_cnt <= 0.
    - tx_shift reloads from holding or TX_IDLE_BYTE, same rule as the CS fall.
  - SCLK falling edge: spi_miso <= tx_shift[7].
  - Synchronised cs_n rises: go to IDLE; partial byte discarded (rx_data/rx_valid untouched); spi_miso_oe <= 0.
  - Simultaneous cs_n rise and SCLK edge in the same clk: cs_n wins and the edge is ignored.
- TX holding register:
  - tx_load writes the holding register and clears tx_empty.
  - A reload at a byte boundary consumes it and sets tx_empty.
  - tx_load in the same cycle as a reload: the reload takes the old holding value (or idle byte), and the new value becomes pending.
  - tx_load while already pending: overwrites the pending byte silently.
- rx_ack and byte completion in the same cycle: completion wins and rx_valid stays 1.
- rx_ack while rx_valid=0: no effect.
- selected mirrors synchronised ~cs_n with no extra delay.

Optional Feature:
- Macro: SIMPLE_SPI_SLAVE_OVERRUN_EN.
- Defined: overrun is set when a byte completes while rx_valid=1 and not simultaneously acked. rx_data is still overwritten with the new byte. overrun is cleared by rx_ack or reset.
- Undefined: overrun is tied to 0 and overwrites are silent. Flop logic is removed.

Decomposition:
- Shared package spi_pkg:
  - SPI_FRAME_BITS=8.
  - State encoding (IDLE=1'b0, ACTIVE=1'b1).
  - Default TX_IDLE_BYTE.
- One natural sub-module: spi_sync_edge. It holds the parameterised synchroniser plus history flop, with rise/fall pulse outputs, and is instantiated for spi_clk and spi_cs_n. spi_mosi uses the synchroniser only.

Test Plan:
1. Reset mid-byte: assert reset_n=0 after 3 SCLK rises → all outputs at reset values immediately, tx_empty=1. After release, a fresh frame decodes correctly.
2. Single byte, f_sclk=clk/8: tx_load 0xA5, master sends 0x3C → master reads 0xA5, rx_data=0x3C, rx_valid=1 within SYNC_STAGES+2 clk of the 8th SCLK rise, tx_empty=1.
3. Back-to-back: load 0x11, CS low, then load 0x22 during the first byte; master sends 0xDE,0xAD → master reads 0x11,0x22, rx sequence 0xDE then 0xAD with an rx_ack between.
4. Empty TX: no tx_load, master sends 0x00 → MISO shifts 0xFF (TX_IDLE_BYTE), rx_data=0x00.
5. CS abort: CS high after 5 bits of 0xF0 → rx_valid stays 0, spi_miso_oe=0. The next full frame of 0x81 gives rx_data=0x81.
6. Overrun (macro defined): send 0x55 then 0x66 with no rx_ack → rx_data=0x66, overrun=1, cleared by rx_ack. Macro undefined → overrun stays 0.
